ps2_scancode_rx: RTL and testbench

PS/2 keyboard receive stage that sits directly upstream of the scancode display logic. It takes the raw `ps2clk`/`ps2data` pins, synchronises and deglitches them, and deframes 11-bit device-to-host frames. It folds the E0 (extended) and F0 (break) prefixes into flags and emits one strobe per complete key code. It runs in the divided PS/2 clock domain (12.5 MHz `clkps2`).

---
 rtl/ps2_scancode_rx.sv | 165 ++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: synchronises and deglitches the pins, deframes 11-bit frames,
// and folds E0/F0 prefixes into flags on each emitted key code.
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 12500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic [7:0] scancode,
    output logic       extended,
    output logic       released,
    output logic       code_valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Data byte plus parity bit must carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    logic                  clk_s1_r, clk_s2_r, dat_s1_r, dat_s2_r;
    logic [FILTER_LEN-1:0] filt_r;
    logic                  lvl_r, fall_r;
    logic                  filt_zero_s, filt_one_s, timeout_s;

    state_t     state_r;
    logic [2:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic       par_r;
    logic [CW-1:0] cnt_r;
    logic       ext_pend_r, rel_pend_r;
    logic [7:0] scancode_r;
    logic       extended_r, released_r, code_valid_r, frame_error_r, busy_r;

    assign filt_zero_s = (filt_r == '0);
    assign filt_one_s  = &filt_r;
    assign timeout_s   = (state_r != IDLE) && (cnt_r == TO_MAX) && !fall_r;

    // Pin synchronisers, clock glitch filter and filtered falling-edge strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_r <= 1'b1;
            clk_s2_r <= 1'b1;
            dat_s1_r <= 1'b1;
            dat_s2_r <= 1'b1;
            filt_r   <= '1;
            lvl_r    <= 1'b1;
            fall_r   <= 1'b0;
        end else begin
            clk_s1_r <= ps2clk;
            clk_s2_r <= clk_s1_r;
            dat_s1_r <= ps2data;
            dat_s2_r <= dat_s1_r;
            filt_r   <= {filt_r[FILTER_LEN-2:0], clk_s2_r};
            if (filt_zero_s) begin
                lvl_r <= 1'b0;
            end else if (filt_one_s) begin
                lvl_r <= 1'b1;
            end else begin
                lvl_r <= lvl_r;
            end
            fall_r <= lvl_r & filt_zero_s;
        end
    end

    // Frame deframer, inter-edge timeout and prefix folding; all outputs registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            bit_cnt_r     <= 3'd0;
            shift_r       <= 8'h00;
            par_r         <= 1'b0;
            cnt_r         <= '0;
            ext_pend_r    <= 1'b0;
            rel_pend_r    <= 1'b0;
            scancode_r    <= 8'h00;
            extended_r    <= 1'b0;
            released_r    <= 1'b0;
            code_valid_r  <= 1'b0;
            frame_error_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            code_valid_r  <= 1'b0;
            frame_error_r <= 1'b0;

            if (fall_r || state_r == IDLE) begin
                cnt_r <= '0;
            end else if (cnt_r != TO_MAX) begin
                cnt_r <= cnt_r + CW'(1);
            end

            if (fall_r) begin
                case (state_r)
                    IDLE: begin
                        if (!dat_s2_r) begin
                            state_r   <= DATA;
                            bit_cnt_r <= 3'd0;
                            busy_r    <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_r   <= {dat_s2_r, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_r   <= dat_s2_r;
                        state_r <= STOP;
                    end
                    STOP: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        if (odd_parity_ok(shift_r, par_r) && dat_s2_r) begin
                            if (shift_r == 8'hE0) begin
                                ext_pend_r <= 1'b1;
                            end else if (shift_r == 8'hF0) begin
                                rel_pend_r <= 1'b1;
                            end else begin
                                scancode_r   <= shift_r;
                                extended_r   <= ext_pend_r;
                                released_r   <= rel_pend_r;
                                code_valid_r <= 1'b1;
                                ext_pend_r   <= 1'b0;
                                rel_pend_r   <= 1'b0;
                            end
                        end else begin
                            frame_error_r <= 1'b1;
                            ext_pend_r    <= 1'b0;
                            rel_pend_r    <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end else if (timeout_s) begin
                // A stalled partial frame is abandoned; a coincident fall takes priority above.
                state_r       <= IDLE;
                busy_r        <= 1'b0;
                frame_error_r <= 1'b1;
                ext_pend_r    <= 1'b0;
                rel_pend_r    <= 1'b0;
            end
        end
    end

    assign scancode    = scancode_r;
    assign extended    = extended_r;
    assign released    = released_r;
    assign code_valid  = code_valid_r;
    assign frame_error = frame_error_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: frames are bit-banged on the pins, expected results
// are queued as frames are sent and compared whenever the receiver pulses.
module tb_ps2_scancode_rx;

    localparam int FL   = 8;
    localparam int TO   = 1000;
    localparam int HALF = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2clk = 1'b1;
    logic       ps2data = 1'b1;
    logic [7:0] scancode;
    logic       extended, released, code_valid, frame_error, busy;

    typedef struct packed {
        logic       err;
        logic [7:0] sc;
        logic       ext;
        logic       rel;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;

    ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ps2clk(ps2clk), .ps2data(ps2data),
        .scancode(scancode), .extended(extended), .released(released),
        .code_valid(code_valid), .frame_error(frame_error), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic err, input logic [7:0] sc, input logic ext, input logic rel);
        exp_t e;
        e.err = err; e.sc = sc; e.ext = ext; e.rel = rel;
        q.push_back(e);
    endtask

    // Drive the first nbits bits of a frame; optional 5-cycle low glitch in the high phase of bit glitch_at.
    task automatic send_frame(input logic [7:0] b, input logic par_ok, input int glitch_at, input int nbits);
        logic [10:0] bits;
        logic        p;
        p    = par_ok ? ~^b : ^b;
        bits = {1'b1, p, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2data = bits[i];
            cyc(HALF);
            ps2clk = 1'b0;
            cyc(HALF);
            ps2clk = 1'b1;
            if (i == glitch_at) begin
                cyc(20);
                ps2clk = 1'b0;
                cyc(5);
                ps2clk = 1'b1;
            end
        end
        ps2data = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && q.size() != 0; i++) cyc(1);
        check("drain", 32'(q.size()), 32'd0);
    endtask

    // Scoreboard: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && (code_valid || frame_error)) begin
            if (q.size() == 0) begin
                check("spurious_pulse", {30'd0, code_valid, frame_error}, 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("pulse_kind", {30'd0, code_valid, frame_error}, {30'd0, !mon_e.err, mon_e.err});
                if (!mon_e.err)
                    check("code", {22'd0, scancode, extended, released},
                          {22'd0, mon_e.sc, mon_e.ext, mon_e.rel});
            end
        end
    end

    initial begin
        int n;
        cyc(5);
        check("reset_outs", {20'd0, scancode, extended, released, code_valid, frame_error, busy}, 32'd0);
        rst_n = 1'b1;
        cyc(5);

        push(1'b0, 8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b1, -1, 11);
        wait_drain();

        // Back-to-back prefixed code, then a plain code with flags cleared.
        push(1'b0, 8'h75, 1'b1, 1'b1);
        send_frame(8'hE0, 1'b1, -1, 11);
        send_frame(8'hF0, 1'b1, -1, 11);
        send_frame(8'h75, 1'b1, -1, 11);
        push(1'b0, 8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b1, -1, 11);
        wait_drain();

        send_frame(8'hF0, 1'b1, -1, 11);
        push(1'b1, 8'h00, 1'b0, 1'b0);
        send_frame(8'h29, 1'b0, -1, 11);
        push(1'b0, 8'h29, 1'b0, 1'b0);
        send_frame(8'h29, 1'b1, -1, 11);
        wait_drain();

        // Short low glitch with data low in idle must not start a frame.
        ps2data = 1'b0;
        ps2clk  = 1'b0;
        cyc(5);
        ps2clk  = 1'b1;
        cyc(20);
        check("idle_glitch_busy", {31'd0, busy}, 32'd0);
        ps2data = 1'b1;
        cyc(20);
        push(1'b0, 8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b1, 3, 11);
        wait_drain();

        // Abort after five data bits and measure the timeout from the last clock drop.
        push(1'b1, 8'h00, 1'b0, 1'b0);
        send_frame(8'h29, 1'b1, -1, 5);
        ps2data = 1'b0;
        cyc(HALF);
        ps2clk = 1'b0;
        n = 0;
        while (n < TO + 100) begin
            @(posedge clk);
            n++;
            #1;
            if (n == HALF) ps2clk = 1'b1;
            if (frame_error) break;
        end
        ps2clk  = 1'b1;
        ps2data = 1'b1;
        check("timeout_cycles", 32'(n), 32'(TO + 12));
        check("timeout_busy", {31'd0, busy}, 32'd0);
        cyc(5);
        push(1'b0, 8'h29, 1'b0, 1'b0);
        send_frame(8'h29, 1'b1, -1, 11);
        wait_drain();

        // Reset mid-frame with an extended prefix pending.
        send_frame(8'hE0, 1'b1, -1, 11);
        send_frame(8'h75, 1'b1, -1, 4);
        check("busy_midframe", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", {20'd0, scancode, extended, released, code_valid, frame_error, busy}, 32'd0);
        cyc(3);
        rst_n = 1'b1;
        cyc(20);
        push(1'b0, 8'h75, 1'b0, 1'b0);
        send_frame(8'h75, 1'b1, -1, 11);
        wait_drain();

        cyc(50);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
